// File: rtl/move_input_ctrl_if.sv
// Player-input bus: key inputs, move handshake toward control, and status outputs.
interface move_input_ctrl_if #(
  parameter int N_KEYS = 4
);
  logic              enable;
  logic [N_KEYS-1:0] keys_n;
  logic              move_ready;
  logic              move_valid;
  logic [N_KEYS-1:0] move;
  logic [N_KEYS-1:0] key_state;
  logic              tick;
  logic              overflow;

  modport master (
    output enable, keys_n, move_ready,
    input  move_valid, move, key_state, tick, overflow
  );

  modport slave (
    input  enable, keys_n, move_ready,
    output move_valid, move, key_state, tick, overflow
  );
endinterface

// File: rtl/move_input_ctrl.sv
// Key front end: sync, tick-based debounce, one one-hot move per press under valid/ready.
// Optional auto-repeat of a single held key is enabled by defining MOVE_AUTO_REPEAT_EN.
module move_input_ctrl #(
  parameter int N_KEYS         = 4,
  parameter int TICK_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 10,
  parameter int REPEAT_TICKS   = 300,
  parameter int CNT_W          = 16
) (
  input  logic            clock,
  input  logic            reset,
  move_input_ctrl_if.slave bus
);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_TICKS - 1);

  logic [N_KEYS-1:0] r_sync1, r_sync2, r_key_state_d, r_move;
  logic [N_KEYS-1:0] w_key_state, w_rise, w_evt_vec, w_evt_onehot;
  logic [CNT_W-1:0]  r_tick_cnt;
  logic              r_move_valid, r_overflow;
  logic              w_tick, w_evt;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= ~bus.keys_n;
      r_sync2 <= r_sync1;
    end
  end

  assign w_tick = bus.enable && (r_tick_cnt == TICK_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_tick_cnt <= '0;
    end else if (bus.enable) begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + CNT_W'(1);
    end
  end

  // Each key accepts a new level only after DEBOUNCE_TICKS consecutive disagreeing ticks.
  genvar gi;
  generate
    for (gi = 0; gi < N_KEYS; gi++) begin : g_db
      logic [CNT_W-1:0] r_db_cnt;
      logic             r_level;

      always_ff @(posedge clock) begin
        if (reset) begin
          r_db_cnt <= '0;
          r_level  <= 1'b0;
        end else if (w_tick) begin
          if (r_sync2[gi] == r_level) begin
            r_db_cnt <= '0;
          end else if (r_db_cnt == DB_LAST) begin
            r_level  <= ~r_level;
            r_db_cnt <= '0;
          end else begin
            r_db_cnt <= r_db_cnt + CNT_W'(1);
          end
        end
      end

      assign w_key_state[gi] = r_level;
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      r_key_state_d <= '0;
    end else begin
      r_key_state_d <= w_key_state;
    end
  end

  assign w_rise = w_key_state & ~r_key_state_d;

`ifdef MOVE_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] RPT_LIM = CNT_W'(REPEAT_TICKS);

  logic [CNT_W-1:0] r_rpt_cnt;
  logic             w_held_one, w_rpt_hit;

  assign w_held_one = $onehot(w_key_state);
  assign w_rpt_hit  = bus.enable && w_held_one && (r_rpt_cnt == RPT_LIM);
  assign w_evt_vec  = bus.enable ? (w_rise | (w_rpt_hit ? w_key_state : '0)) : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rpt_cnt <= '0;
    end else if (w_evt || !w_held_one) begin
      r_rpt_cnt <= '0;
    end else if (w_tick) begin
      r_rpt_cnt <= r_rpt_cnt + CNT_W'(1);
    end
  end
`else
  assign w_evt_vec = bus.enable ? w_rise : '0;
`endif

  // Isolate the lowest set bit so simultaneous presses yield a single move.
  assign w_evt_onehot = w_evt_vec & (~w_evt_vec + N_KEYS'(1));
  assign w_evt        = |w_evt_vec;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_move_valid <= 1'b0;
      r_move       <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_overflow <= 1'b0;
      if (w_evt) begin
        if (!r_move_valid || bus.move_ready) begin
          r_move_valid <= 1'b1;
          r_move       <= w_evt_onehot;
        end else begin
          r_overflow <= 1'b1;
        end
      end else if (r_move_valid && bus.move_ready) begin
        r_move_valid <= 1'b0;
        r_move       <= '0;
      end
    end
  end

  assign bus.move_valid = r_move_valid;
  assign bus.move       = r_move;
  assign bus.key_state  = w_key_state;
  assign bus.tick       = w_tick;
  assign bus.overflow   = r_overflow;
endmodule

// File: tb/tb_move_input_ctrl.sv
// Directed scenarios plus random key/ready/enable traffic against a behavioural model.
module tb_move_input_ctrl;
  localparam int NK = 4;
  localparam int TD = 4;
  localparam int DB = 3;
  localparam int RT = 5;
`ifdef MOVE_AUTO_REPEAT_EN
  localparam int EXP_EVENTS = 4;
  localparam bit RPT_ON = 1'b1;
`else
  localparam int EXP_EVENTS = 1;
  localparam bit RPT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  move_input_ctrl_if #(.N_KEYS(NK)) bus ();

  move_input_ctrl #(
    .N_KEYS(NK), .TICK_DIV(TD), .DEBOUNCE_TICKS(DB), .REPEAT_TICKS(RT), .CNT_W(16)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus)
  );

  int total = 0;
  int bad = 0;

  // Model state: synchroniser stages, accepted levels, run of disagreeing ticks,
  // one-entry pending slot, enabled-cycle count since reset, repeat tick count.
  logic [3:0] m_s1, m_s2, m_lvl, m_lvl_prev, m_move;
  logic       m_valid, m_ovf;
  int         m_en_cycles, m_rpt;
  int         m_disagree [4];
  bit         m_live = 1'b0;

  int         accepted;
  logic [3:0] last_acc;
  int         ovf_seen;
  bit         valid_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Inputs are set by the caller just after an edge; check, advance model, take one edge.
  task automatic step();
    logic       m_tick, hit;
    logic [3:0] ev;
    int         idx, held;
    #2;
    m_tick = bus.enable && ((m_en_cycles % TD) == TD - 1);
    if (m_live) begin
      chk("tick", bus.tick, m_tick);
      chk("valid", bus.move_valid, m_valid);
      chk("move", bus.move, m_move);
      chk("key_state", bus.key_state, m_lvl);
      chk("overflow", bus.overflow, m_ovf);
    end
    if (bus.move_valid && bus.move_ready) begin
      accepted++;
      last_acc = bus.move;
    end
    if (bus.overflow) ovf_seen++;
    if (bus.move_valid) valid_seen = 1'b1;

    if (rst) begin
      m_live = 1'b1;
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_lvl_prev = '0; m_move = '0;
      m_valid = 1'b0; m_ovf = 1'b0; m_en_cycles = 0; m_rpt = 0;
      for (int i = 0; i < 4; i++) m_disagree[i] = 0;
    end else begin
      held = $countones(m_lvl);
      hit  = RPT_ON && bus.enable && (held == 1) && (m_rpt == RT);
      ev   = bus.enable ? ((m_lvl & ~m_lvl_prev) | (hit ? m_lvl : 4'b0)) : 4'b0;
      idx  = lowest(ev);
      if (idx >= 0) begin
        if (!m_valid || bus.move_ready) begin
          m_valid = 1'b1;
          m_move  = 4'(1 << idx);
          m_ovf   = 1'b0;
        end else begin
          m_ovf = 1'b1;
        end
      end else begin
        m_ovf = 1'b0;
        if (m_valid && bus.move_ready) begin
          m_valid = 1'b0;
          m_move  = '0;
        end
      end
      if (idx >= 0 || held != 1) m_rpt = 0;
      else if (m_tick) m_rpt++;
      m_lvl_prev = m_lvl;
      if (m_tick) begin
        for (int i = 0; i < 4; i++) begin
          if (m_s2[i] == m_lvl[i]) m_disagree[i] = 0;
          else begin
            m_disagree[i]++;
            if (m_disagree[i] == DB) begin
              m_lvl[i] = ~m_lvl[i];
              m_disagree[i] = 0;
            end
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = ~bus.keys_n;
      if (bus.enable) m_en_cycles++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    rst = 1'b1;
    bus.keys_n = 4'hF;
    bus.move_ready = 1'b0;
    bus.enable = 1'b1;
    accepted = 0; ovf_seen = 0; valid_seen = 1'b0; last_acc = '0;
    @(posedge clk);
    #1;
    run(3);
    rst = 1'b0;
    chk("rst_valid", bus.move_valid, 0);
    chk("rst_move", bus.move, 0);
    chk("rst_keys", bus.key_state, 0);
    chk("rst_ovf", bus.overflow, 0);
    chk("rst_tick", bus.tick, 0);
    run(8);

    // Single press held with control stalled, then one acknowledge.
    bus.keys_n = 4'b1110;
    run(24);
    chk("press_keys", bus.key_state, 4'b0001);
    chk("press_valid", bus.move_valid, 1);
    chk("press_move", bus.move, 4'b0001);
    bus.move_ready = 1'b1;
    step();
    bus.move_ready = 1'b0;
    chk("ack_valid", bus.move_valid, 0);
    chk("ack_move", bus.move, 0);
    bus.move_ready = 1'b1;
    bus.keys_n = 4'hF;
    run(24);
    chk("release_keys", bus.key_state, 0);
    bus.move_ready = 1'b0;

    // Glitch of two ticks is rejected.
    valid_seen = 1'b0;
    bus.keys_n = 4'b1011;
    run(8);
    bus.keys_n = 4'hF;
    run(24);
    chk("glitch_keys", bus.key_state, 0);
    chk("glitch_valid", 32'(valid_seen), 0);

    // Keys 1 and 3 together: lowest index wins, nothing dropped.
    ovf_seen = 0;
    bus.keys_n = 4'b0101;
    run(24);
    chk("pair_move", bus.move, 4'b0010);
    chk("pair_ovf", ovf_seen, 0);
    bus.move_ready = 1'b1;
    bus.keys_n = 4'hF;
    run(24);
    bus.move_ready = 1'b0;

    // Second press while the first move is still pending is dropped.
    bus.keys_n = 4'b1110;
    run(24);
    chk("pend_move", bus.move, 4'b0001);
    ovf_seen = 0;
    bus.keys_n = 4'b1100;
    run(24);
    chk("drop_move", bus.move, 4'b0001);
    chk("drop_ovf", 32'(ovf_seen >= 1), 1);
    bus.move_ready = 1'b1;
    bus.keys_n = 4'hF;
    run(30);

    // Key 3 held for 72 clocks (18 ticks) with control always ready.
    accepted = 0;
    bus.keys_n = 4'b0111;
    run(72);
    bus.keys_n = 4'hF;
    run(30);
    chk("hold_events", accepted, EXP_EVENTS);
    chk("hold_move", last_acc, 4'b1000);
    bus.move_ready = 1'b0;

    // Random traffic: key patterns held for random spans, random ready and enable.
    for (int r = 0; r < 40; r++) begin
      bus.keys_n = 4'($urandom);
      for (int c = 0; c < int'($urandom_range(1, 20)); c++) begin
        bus.move_ready = 1'($urandom_range(0, 1));
        bus.enable = ($urandom_range(0, 7) != 0);
        step();
      end
    end
    bus.enable = 1'b1;
    bus.keys_n = 4'hF;
    bus.move_ready = 1'b1;
    run(30);
    chk("final_valid", bus.move_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
